// File: rtl/jtag_uart_pkg.sv
// Shared constants and types for the JTAG UART register-map responder.
// Field positions follow the vendor JTAG UART DATA/CONTROL register layout.
package jtag_uart_pkg;

  localparam int unsigned DATA_ADDR_BIT = 2;
  localparam int unsigned RVALID_BIT    = 15;
  localparam int unsigned RAVAIL_LSB    = 16;
  localparam int unsigned WSPACE_LSB    = 16;

  typedef logic [7:0] char_t;

endpackage

// File: rtl/jtag_uart_responder_stream_fifo.sv
// Power-of-two synchronous FIFO with occupancy count and read-first head.
// Push is refused when full and pop when empty, both judged on registered state.
module stream_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      pushData,
  output logic                  full,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned             DEPTH     = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]     DEPTH_C   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]     CNT_ONE_C = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0]   PTR_ONE_C = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {(DEPTH_LOG2+1){1'b0}});
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      count_r  <= {(DEPTH_LOG2+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE_C;
        2'b01:   count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; no reset needed since occupancy gates every read.
  always_ff @(posedge clock) begin
    if (push_ok_s && !reset) mem_r[wr_ptr_r] <= pushData;
  end

endmodule

// File: rtl/jtag_uart_responder.sv
// Avalon-MM target modelling the JTAG UART DATA/CONTROL registers, with an
// RX FIFO filled from an input stream and a TX FIFO drained to an output stream.
module jtag_uart_responder
  import jtag_uart_pkg::*;
#(
  parameter int unsigned RX_DEPTH_LOG2 = 4,
  parameter int unsigned TX_DEPTH_LOG2 = 4,
  parameter int unsigned WAIT_CYCLES   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  input  logic        write,
  input  logic        read,
  output logic        waitrequest,
  output logic [31:0] readdata,
  input  logic        in_canGet,
  input  logic [7:0]  in_getData,
  output logic        in_get,
  output logic        out_canGet,
  output logic [7:0]  out_getData,
  input  logic        out_get,
  output logic        tx_overflow
);

  localparam logic [3:0]  WAIT_C     = 4'(WAIT_CYCLES);
  localparam logic [15:0] TX_DEPTH_C = 16'(32'd1 << TX_DEPTH_LOG2);

  logic [3:0]             cnt_r;
  logic                   overflow_r;
  logic                   req_s, stall_s, done_s, wr_done_s, rd_done_s, is_data_s;
  logic                   rx_pop_s, rx_full_s, rx_empty_s;
  logic                   tx_push_s, tx_full_s, tx_empty_s;
  char_t                  rx_head_s, tx_head_s;
  logic [RX_DEPTH_LOG2:0] rx_count_s;
  logic [TX_DEPTH_LOG2:0] tx_count_s;
  logic [31:0]            readdata_s;
  logic                   unused_s;

  assign req_s       = read || write;
  assign stall_s     = req_s && (cnt_r != WAIT_C);
  assign waitrequest = reset || stall_s;
  assign done_s      = req_s && !waitrequest;
  // A simultaneous read and write is serviced as a write only.
  assign wr_done_s   = write && done_s;
  assign rd_done_s   = read && !write && done_s;
  assign is_data_s   = !address[DATA_ADDR_BIT];

  assign rx_pop_s    = rd_done_s && is_data_s && !rx_empty_s;
  assign tx_push_s   = wr_done_s && is_data_s;
  assign in_get      = in_canGet && !rx_full_s && !reset;
  assign out_canGet  = !tx_empty_s;
  assign out_getData = tx_head_s;
  assign tx_overflow = overflow_r;
  assign readdata    = readdata_s;
  assign unused_s    = ^{address[1:0], writedata[31:8]};

  // Wait-state counter: counts stalled request cycles, clears otherwise.
  always_ff @(posedge clock) begin
    if (reset)        cnt_r <= 4'd0;
    else if (stall_s) cnt_r <= cnt_r + 4'd1;
    else              cnt_r <= 4'd0;
  end

  // Sticky flag for a DATA write dropped against a full TX FIFO.
  always_ff @(posedge clock) begin
    if (reset)                       overflow_r <= 1'b0;
    else if (tx_push_s && tx_full_s) overflow_r <= 1'b1;
    else                             overflow_r <= overflow_r;
  end

  // Read-data mux; zero outside read completions.
  always_comb begin
    readdata_s = 32'h0000_0000;
    if (rd_done_s) begin
      if (is_data_s) begin
        if (!rx_empty_s) begin
          readdata_s[7:0]                 = rx_head_s;
          readdata_s[RVALID_BIT]          = 1'b1;
          readdata_s[RAVAIL_LSB +: 16]    = 16'(rx_count_s) - 16'd1;
        end else begin
          readdata_s = 32'h0000_0000;
        end
      end else begin
        readdata_s[WSPACE_LSB +: 16] = TX_DEPTH_C - 16'(tx_count_s);
      end
    end else begin
      readdata_s = 32'h0000_0000;
    end
  end

  stream_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (in_get),
    .pushData (in_getData),
    .full     (rx_full_s),
    .pop      (rx_pop_s),
    .head     (rx_head_s),
    .empty    (rx_empty_s),
    .count    (rx_count_s)
  );

  stream_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (tx_push_s),
    .pushData (writedata[7:0]),
    .full     (tx_full_s),
    .pop      (out_get),
    .head     (tx_head_s),
    .empty    (tx_empty_s),
    .count    (tx_count_s)
  );

endmodule

// File: tb/tb_jtag_uart_responder.sv
// Self-checking bench: queue-based register-map model checked every cycle,
// plus directed literal checks and a randomized loopback through the master role.
module tb_jtag_uart_responder;

  localparam int W   = 1;
  localparam int DEP = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic [31:0] writedata = 32'h0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        in_canGet = 1'b0;
  logic [7:0]  in_getData = 8'h00;
  logic        in_get;
  logic        out_canGet;
  logic [7:0]  out_getData;
  logic        out_get = 1'b0;
  logic        tx_overflow;

  jtag_uart_responder #(.RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(4), .WAIT_CYCLES(W)) dut (
    .clock(clock), .reset(reset), .address(address), .writedata(writedata),
    .write(write), .read(read), .waitrequest(waitrequest), .readdata(readdata),
    .in_canGet(in_canGet), .in_getData(in_getData), .in_get(in_get),
    .out_canGet(out_canGet), .out_getData(out_getData), .out_get(out_get),
    .tx_overflow(tx_overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] rxq[$], txq[$], src_q[$], got_q[$];
  int  cnt_m    = 0;
  bit  ovf_m    = 1'b0;
  bit  model_ok = 1'b0;
  bit  in_taken = 1'b0;
  bit  src_en   = 1'b0;
  bit  sink_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: compare outputs, then advance queues to the next edge.
  always @(negedge clock) begin : model
    bit req, stall, done, wrd, rdd, dat, rxp, rxpush, txp, txpush;
    logic [31:0] exp_rd;
    req   = read || write;
    stall = req && (cnt_m != W);
    done  = req && !stall && !reset;
    wrd   = write && done;
    rdd   = read && !write && done;
    dat   = !address[2];
    exp_rd = 32'h0;
    if (rdd) begin
      if (dat) begin
        if (rxq.size() > 0) exp_rd = {16'(rxq.size() - 1), 8'h80, rxq[0]};
      end else begin
        exp_rd = {16'(DEP - txq.size()), 16'h0000};
      end
    end
    if (model_ok) begin
      check("waitrequest", 32'(waitrequest), 32'(reset || stall));
      check("readdata", readdata, exp_rd);
      check("in_get", 32'(in_get), 32'(in_canGet && rxq.size() < DEP && !reset));
      check("out_canGet", 32'(out_canGet), 32'(txq.size() > 0));
      if (txq.size() > 0) check("out_getData", 32'(out_getData), 32'(txq[0]));
      check("tx_overflow", 32'(tx_overflow), 32'(ovf_m));
    end
    in_taken = in_get;
    if (!reset && out_get && out_canGet) got_q.push_back(out_getData);
    if (reset) begin
      rxq.delete(); txq.delete();
      cnt_m = 0; ovf_m = 1'b0; model_ok = 1'b1;
    end else begin
      rxp    = rdd && dat && rxq.size() > 0;
      rxpush = in_canGet && rxq.size() < DEP;
      txp    = out_get && txq.size() > 0;
      txpush = wrd && dat && txq.size() < DEP;
      if (wrd && dat && txq.size() == DEP) ovf_m = 1'b1;
      cnt_m = stall ? cnt_m + 1 : 0;
      if (rxp)    void'(rxq.pop_front());
      if (rxpush) rxq.push_back(in_getData);
      if (txp)    void'(txq.pop_front());
      if (txpush) txq.push_back(writedata[7:0]);
    end
  end

  // Stream source and sink drivers.
  always @(posedge clock) begin
    if (in_taken) void'(src_q.pop_front());
    #1;
    in_canGet  = src_en && src_q.size() > 0;
    in_getData = (src_q.size() > 0) ? src_q[0] : 8'h00;
    out_get    = sink_en && ($urandom_range(0, 3) != 0);
  end

  task automatic access(input bit wr, input bit ctrl, input logic [31:0] wd,
                        output logic [31:0] rd, output int stalls);
    int n;
    bit ok;
    n = 0; ok = 1'b0; stalls = 0; rd = 32'h0;
    @(posedge clock); #1;
    address = ctrl ? 3'd4 : 3'd0; writedata = wd; write = wr; read = !wr;
    while (!ok && n < 40) begin
      @(negedge clock);
      if (!waitrequest) begin ok = 1'b1; rd = readdata; end
      else stalls++;
      n++;
    end
    if (!ok) check("access_timeout", 32'(waitrequest), 32'h0);
    @(posedge clock); #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: no finish by %0t, required earlier", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  exp_chars[$];
    int st, sent, n;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    access(1'b0, 1'b1, 32'h0, rd, st);
    check("ctrl_after_reset", rd, 32'h0010_0000);
    check("stall_cycles", 32'(st), 32'd1);

    src_q.push_back(8'h41); src_q.push_back(8'h42); src_en = 1'b1;
    repeat (4) @(posedge clock);
    access(1'b0, 1'b0, 32'h0, rd, st); check("rx_read_A", rd, 32'h0001_8041);
    access(1'b0, 1'b0, 32'h0, rd, st); check("rx_read_B", rd, 32'h0000_8042);
    access(1'b0, 1'b0, 32'h0, rd, st); check("rx_read_empty", rd, 32'h0000_0000);

    access(1'b1, 1'b0, 32'h0000_0048, rd, st);
    @(negedge clock);
    check("tx_canGet_H", 32'(out_canGet), 32'd1);
    check("tx_head_H", 32'(out_getData), 32'h48);
    access(1'b0, 1'b1, 32'h0, rd, st); check("wspace_15", rd, 32'h000F_0000);

    do_reset();
    for (int i = 0; i < 17; i++) access(1'b1, 1'b0, 32'h30 + 32'(i), rd, st);
    @(negedge clock);
    check("tx_overflow_set", 32'(tx_overflow), 32'd1);
    access(1'b0, 1'b1, 32'h0, rd, st); check("wspace_0", rd, 32'h0000_0000);
    got_q.delete(); sink_en = 1'b1;
    n = 0;
    while (got_q.size() < 16 && n < 300) begin @(posedge clock); n++; end
    check("tx_drain_count", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < got_q.size()) check("tx_drain_char", 32'(got_q[i]), 32'h30 + 32'(i));
    sink_en = 1'b0;

    do_reset();
    for (int i = 0; i < 20; i++) src_q.push_back(8'h60 + 8'(i));
    repeat (30) @(posedge clock);
    @(negedge clock);
    check("rx_full_in_get", 32'(in_get), 32'd0);
    check("src_left", 32'(src_q.size()), 32'd4);
    access(1'b0, 1'b0, 32'h0, rd, st); check("rx_full_read", rd, 32'h000F_8060);
    for (int i = 0; i < 3; i++) access(1'b0, 1'b0, 32'h0, rd, st);
    repeat (6) @(posedge clock);
    check("src_refilled", 32'(src_q.size()), 32'd0);

    src_en = 1'b0;
    @(posedge clock); #1;
    address = 3'd0; writedata = 32'h5A; write = 1'b1; reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("abort_no_push", 32'(out_canGet), 32'd0);
    n = 0;
    while (waitrequest && n < 20) begin @(negedge clock); n++; end
    check("reissue_complete", 32'(waitrequest), 32'd0);
    @(posedge clock); #1 write = 1'b0;
    @(negedge clock);
    check("reissue_canGet", 32'(out_canGet), 32'd1);
    check("reissue_head", 32'(out_getData), 32'h5A);

    do_reset();
    got_q.delete();
    for (int i = 0; i < 64; i++) begin
      exp_chars.push_back(8'($urandom));
      src_q.push_back(exp_chars[i]);
    end
    src_en = 1'b1; sink_en = 1'b1;
    sent = 0; n = 0;
    while (sent < 64 && n < 2000) begin
      n++;
      access(1'b0, 1'b0, 32'h0, rd, st);
      if (rd[15]) begin
        logic [31:0] cr;
        int k;
        k = 0;
        cr = 32'h0;
        while (cr[31:16] == 16'h0 && k < 100) begin access(1'b0, 1'b1, 32'h0, cr, st); k++; end
        access(1'b1, 1'b0, {24'h0, rd[7:0]}, cr, st);
        sent++;
      end
    end
    n = 0;
    while (got_q.size() < 64 && n < 500) begin @(posedge clock); n++; end
    check("loop_count", 32'(got_q.size()), 32'd64);
    for (int i = 0; i < 64; i++)
      if (i < got_q.size()) check("loop_char", 32'(got_q[i]), 32'(exp_chars[i]));
    check("loop_no_overflow", 32'(tx_overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
